apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB completer (slave) end of the team's APB interface: decodes PSEL/PENABLE/PWRITE/PADDR,
//  inserts programmable wait states via PREADY, and services reads/writes to a bank of
//  NUM_REGS software registers. Also drives read data onto the shared PDATA bus.
//  Instantiated behind the interconnect; register contents are exported flat to the core logic.
// PARAMETERS
//  DATA_WIDTH   32  PDATA/register width; multiple of 8
//  NUM_REGS     16  number of registers; >=1
//  WAIT_CYCLES  0   wait states inserted per transfer (0 = zero-wait APB)
//  BASE_ADDR    0   byte address of register 0
// PORTS
//  PCLK      in     1                    clock, all logic rising-edge
//  PRESET    in     1                    asynchronous, active-high reset
//  PSEL      in     1                    slave select
//  PENABLE   in     1                    access phase
//  PWRITE    in     1                    1 = write, 0 = read
//  PADDR     in     32                   byte address
//  PDATA     inout  DATA_WIDTH           shared data; slave drives only during read ACCESS
//  PREADY    out    1                    transfer complete
//  PSLVERR   out    1                    (APB_SLV_ERR_EN only) error response
//  regs_o    out    NUM_REGS*DATA_WIDTH  register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset: state=IDLE, PREADY=0, PSLVERR=0, all registers 0, PDATA released ('z), counter 0.
//  Decode: offset=PADDR-BASE_ADDR; idx=offset>>log2(DATA_WIDTH/8); byte-lane bits ignored;
//   in-range iff PADDR>=BASE_ADDR and idx<NUM_REGS.
//  FSM (registered, 2 states):
//   IDLE:   PSEL&!PENABLE (setup) -> ACCESS; latch idx, in-range flag, PWRITE; load
//           count=WAIT_CYCLES; read data register <= reg[idx] (0 if out of range);
//           PREADY<=(WAIT_CYCLES==0). PENABLE without preceding setup: ignored.
//   ACCESS: count>0 -> decrement; PREADY<=1 on the edge count goes 1->0.
//           PSEL&PENABLE&PREADY at edge: commit (write: reg[idx]<=PDATA if in range),
//           PREADY<=0, -> IDLE. Next setup may arrive the very next cycle (back-to-back).
//           PSEL==0 (master abort): -> IDLE, PREADY<=0, no write.
//  Latency: transfer = 2+WAIT_CYCLES cycles from setup to completing edge.
//  PDATA drive: read data register when state==ACCESS && !write_q, else 'z. Never driven
//   during writes; latched read value stable for whole access phase even if PADDR changes.
//  Out of range: writes dropped, reads return 0; PREADY timing identical to in-range.
//  Reset mid-transfer: immediate return to IDLE, PDATA released, pending write discarded.
//  regs_o reflects register state; updates the cycle after the completing edge.
// CONFIGURATION
//  APB_SLV_ERR_EN defined: PSLVERR port exists; PSLVERR<=1 together with PREADY for
//   out-of-range transfers, 0 otherwise; cleared with PREADY. Without it: no PSLVERR port,
//   out-of-range transfers complete silently as above.
// STRUCTURE
//  apb_pkg: apb_slv_state_e {IDLE, ACCESS}; localparams for byte-lane width, idx width
//   ($clog2(NUM_REGS)), counter width ($clog2(WAIT_CYCLES+1)).
//  Sub-module apb_slave_regbank: register storage, write port (we, idx, wdata), read mux,
//   regs_o flattening. Top holds FSM, wait counter, decode, PDATA tristate.
// TESTING
//  1 Defaults: write 0xDEADBEEF to 0x08, read 0x08 -> PREADY high in 2nd cycle, PDATA=0xDEADBEEF,
//    regs_o[2*32+:32]=0xDEADBEEF.
//  2 WAIT_CYCLES=3: read -> PREADY low 3 access cycles, high on 4th; PDATA stable throughout.
//  3 Back-to-back write 0x00 then read 0x00 with no idle cycle -> both complete, read=written.
//  4 Write to 0x40 (NUM_REGS=16) -> no reg change, read 0x40 returns 0; with APB_SLV_ERR_EN
//    PSLVERR=1 coincident with PREADY.
//  5 PSEL dropped during ACCESS with WAIT_CYCLES=2 -> FSM IDLE, target reg unchanged, PDATA 'z.
//  6 PRESET asserted mid-write -> PREADY=0, all regs 0 asynchronously, next transfer normal.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB completer register file.
// Sizes depend on instance parameters, so they are provided as functions.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    localparam int APB_ADDR_W = 32;

    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // A zero-wait build still needs a one-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_regbank.sv
// Register storage for the APB completer: one synchronous write port,
// a combinational read mux and a flat export of every register.
module apb_slave_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 4
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_we,
    input  logic [IDX_W-1:0]               i_widx,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [IDX_W-1:0]               i_ridx,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_widx] <= i_wdata;
        end
    end

    // Indices beyond NUM_REGS are masked to zero by the caller.
    assign o_rdata = r_regs[i_ridx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states servicing a bank of software registers.
// Optional error response enabled by defining APB_SLV_ERR_EN (adds the PSLVERR port).
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
)(
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [APB_ADDR_W-1:0]          PADDR,
    inout  wire  [DATA_WIDTH-1:0]          PDATA,
    output logic                           PREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
`ifdef APB_SLV_ERR_EN
    ,
    output logic                           PSLVERR
`endif
);

    localparam int LANE_BITS = lane_bits(DATA_WIDTH);
    localparam int IDX_W     = idx_width(NUM_REGS);
    localparam int CNT_W     = cnt_width(WAIT_CYCLES);

    apb_slv_state_e r_state;
    apb_slv_state_e w_state_nxt;

    logic [IDX_W-1:0]      r_idx;
    logic                  r_in_range;
    logic                  r_write;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ready;

    logic [APB_ADDR_W-1:0] w_offset;
    logic [APB_ADDR_W-1:0] w_idx_full;
    logic [IDX_W-1:0]      w_ridx;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_setup;
    logic                  w_commit;
    logic                  w_abort;
    logic                  w_we;

    // Byte-lane bits drop out of the shift; an address below the base wraps and fails the range test.
    assign w_offset   = PADDR - BASE_ADDR;
    assign w_idx_full = w_offset >> LANE_BITS;
    assign w_ridx     = w_idx_full[IDX_W-1:0];
    assign w_in_range = (PADDR >= BASE_ADDR) && (w_idx_full < APB_ADDR_W'(NUM_REGS));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    w_state_nxt = IDLE;
                end else if (PENABLE && r_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_setup  = (r_state == IDLE) && PSEL && !PENABLE;
        w_commit = (r_state == ACCESS) && PSEL && PENABLE && r_ready;
        w_abort  = (r_state == ACCESS) && !PSEL;
        w_we     = w_commit && r_write && r_in_range;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_idx      <= '0;
            r_in_range <= 1'b0;
            r_write    <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
        end else if (w_setup) begin
            r_idx      <= w_ridx;
            r_in_range <= w_in_range;
            r_write    <= PWRITE;
            r_cnt      <= CNT_W'(WAIT_CYCLES);
            r_rdata    <= w_in_range ? w_rd : '0;
            r_ready    <= (WAIT_CYCLES == 0);
        end else if (w_commit || w_abort) begin
            r_ready    <= 1'b0;
        end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
            r_cnt      <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_ready <= 1'b1;
            end
        end
    end

`ifdef APB_SLV_ERR_EN
    logic r_err;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_err <= 1'b0;
        end else if (w_setup) begin
            r_err <= (WAIT_CYCLES == 0) && !w_in_range;
        end else if (w_commit || w_abort) begin
            r_err <= 1'b0;
        end else if ((r_state == ACCESS) && (r_cnt == CNT_W'(1))) begin
            r_err <= !r_in_range;
        end
    end

    assign PSLVERR = r_err;
`endif

    assign PREADY = r_ready;
    assign PDATA  = ((r_state == ACCESS) && !r_write) ? r_rdata : 'z;

    apb_slave_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wdata (PDATA),
        .i_ridx  (w_ridx),
        .o_rdata (w_rd),
        .o_regs  (regs_o)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a zero-wait instance at base 0 and a
// three-wait instance at base 0x100, driven from a vector table plus corner sequences.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic        drv = 1'b0;
    logic [31:0] wd = '0;
    logic        use3 = 1'b0;

    wire [31:0]  pdata0;
    wire [31:0]  pdata3;
    wire         pready0;
    wire         pready3;
    wire [511:0] regs0;
    wire [511:0] regs3;
    wire         err0;
    wire         err3;

    assign pdata0 = drv ? wd : 'z;
    assign pdata3 = drv ? wd : 'z;

    always #5 clk = ~clk;

    apb_slave_regfile #(
        .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)
    ) u_dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PDATA(pdata0), .PREADY(pready0), .regs_o(regs0)
`ifdef APB_SLV_ERR_EN
        , .PSLVERR(err0)
`endif
    );

    apb_slave_regfile #(
        .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h100)
    ) u_dut3 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PDATA(pdata3), .PREADY(pready3), .regs_o(regs3)
`ifdef APB_SLV_ERR_EN
        , .PSLVERR(err3)
`endif
    );

`ifndef APB_SLV_ERR_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    wire         rdy_m  = use3 ? pready3 : pready0;
    wire [31:0]  data_m = use3 ? pdata3 : pdata0;
    wire         err_m  = use3 ? err3 : err0;
    wire [511:0] regs_m = use3 ? regs3 : regs0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m0 [16];
    logic [31:0] m3 [16];

    typedef struct {
        bit          s3;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          widx;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_wait;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] flat(input bit s3);
        logic [511:0] f;
        for (int i = 0; i < 16; i++) begin
            f[i*32 +: 32] = s3 ? m3[i] : m0[i];
        end
        return f;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            m0[i] = '0;
            m3[i] = '0;
        end
    endtask

    task automatic idle();
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        drv     = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge with a setup phase and returns at the negedge after the completing edge,
    // leaving the bus selected so the caller can chain a back-to-back transfer.
    task automatic xfer(input string nm, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int widx, input logic [31:0] exp_rd,
                        input bit exp_err, input int exp_wait);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        psel0   = !use3;
        psel3   = use3;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        drv     = wr;
        wd      = data;
        @(negedge clk);
        penable = 1'b1;
        paddr   = ~addr;
        while (!rdy_m && n < 20) begin
            if (!wr && data_m !== exp_rd) bad++;
            @(negedge clk);
            n++;
        end
        chk({nm, " wait"}, 512'(n), 512'(exp_wait));
        if (!wr) begin
            chk({nm, " rdata"}, 512'(data_m), 512'(exp_rd));
            chk({nm, " rdata_stable"}, 512'(bad), 512'(0));
        end
`ifdef APB_SLV_ERR_EN
        chk({nm, " pslverr"}, 512'(err_m), 512'(exp_err));
`endif
        @(negedge clk);
        if (wr && widx >= 0) begin
            if (use3) m3[widx] = data;
            else      m0[widx] = data;
        end
        chk({nm, " regs"}, regs_m, flat(use3));
        chk({nm, " pready_clr"}, 512'(rdy_m), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        clear_models();
        vt[0]  = '{0, 1, 32'h08,  32'hDEADBEEF, 2,  32'h0,        0, 0};
        vt[1]  = '{0, 0, 32'h08,  32'h0,        -1, 32'hDEADBEEF, 0, 0};
        vt[2]  = '{0, 1, 32'h3C,  32'h12345678, 15, 32'h0,        0, 0};
        vt[3]  = '{0, 0, 32'h3E,  32'h0,        -1, 32'h12345678, 0, 0};
        vt[4]  = '{0, 1, 32'h40,  32'hCAFEF00D, -1, 32'h0,        1, 0};
        vt[5]  = '{0, 0, 32'h40,  32'h0,        -1, 32'h0,        1, 0};
        vt[6]  = '{1, 1, 32'h104, 32'hA5A5A5A5, 1,  32'h0,        0, 3};
        vt[7]  = '{1, 0, 32'h104, 32'h0,        -1, 32'hA5A5A5A5, 0, 3};
        vt[8]  = '{1, 1, 32'hFC,  32'h11111111, -1, 32'h0,        1, 3};
        vt[9]  = '{1, 0, 32'hFC,  32'h0,        -1, 32'h0,        1, 3};
        vt[10] = '{1, 0, 32'h100, 32'h0,        -1, 32'h0,        0, 3};
        vt[11] = '{0, 0, 32'h00,  32'h0,        -1, 32'h0,        0, 0};

        // Reset state
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        drv = 1'b1;
        wd  = 32'h0;
        #1;
        chk("rst pready0", 512'(pready0), 512'(0));
        chk("rst pready3", 512'(pready3), 512'(0));
        chk("rst regs0", regs0, 512'(0));
        chk("rst pdata0 released", 512'(pdata0), 512'(0));
`ifdef APB_SLV_ERR_EN
        chk("rst pslverr", 512'(err0), 512'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 12; i++) begin
            use3 = vt[i].s3;
            xfer($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].data, vt[i].widx,
                 vt[i].exp_rd, vt[i].exp_err, vt[i].exp_wait);
            idle();
        end

        // Back-to-back write then read, no idle cycle between
        use3 = 1'b0;
        xfer("b2b0 wr", 1, 32'h00, 32'h13579BDF, 0, 32'h0, 0, 0);
        xfer("b2b0 rd", 0, 32'h00, 32'h0, -1, 32'h13579BDF, 0, 0);
        idle();
        use3 = 1'b1;
        xfer("b2b3 wr", 1, 32'h108, 32'h0F0F0F0F, 2, 32'h0, 0, 3);
        xfer("b2b3 rd", 0, 32'h108, 32'h0, -1, 32'h0F0F0F0F, 0, 3);
        idle();

        // Master abort of a waited write: no PREADY, no register update
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10C;
        drv = 1'b1; wd = 32'hFFFF0000;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel3 = 1'b0; penable = 1'b0; drv = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (pready3 !== 1'b0) bad++;
        end
        chk("abort wr pready", 512'(bad), 512'(0));
        chk("abort wr regs", regs3, flat(1));

        // Master abort of a waited read: bus released afterwards
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h104;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("abort rd driving", 512'(pdata3), 512'(32'hA5A5A5A5));
        psel3 = 1'b0; penable = 1'b0;
        @(negedge clk);
        drv = 1'b1; wd = 32'h0;
        #1;
        chk("abort rd released", 512'(pdata3), 512'(0));
        chk("abort rd pready", 512'(pready3), 512'(0));
        drv = 1'b0;
        @(negedge clk);
        use3 = 1'b1;
        xfer("post abort rd", 0, 32'h104, 32'h0, -1, 32'hA5A5A5A5, 0, 3);
        idle();

        // Reset asserted in the middle of a write
        use3 = 1'b0;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
        drv = 1'b1; wd = 32'h55555555;
        @(negedge clk);
        penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        clear_models();
        chk("midrst pready", 512'(pready0), 512'(0));
        chk("midrst regs0", regs0, 512'(0));
        chk("midrst regs3", regs3, 512'(0));
        @(negedge clk);
        rst = 1'b0;
        idle();
        xfer("postrst wr", 1, 32'h08, 32'h55555555, 2, 32'h0, 0, 0);
        xfer("postrst rd", 0, 32'h08, 32'h0, -1, 32'h55555555, 0, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
